// File: rtl/line_clear_ctrl_if.sv
// Control and board-RAM port bundle between the line-clear sequencer (master)
// and the game FSM / board RAM side (slave).
interface line_clear_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [4:0] lines_cleared;
   logic [3:0] board_rx;
   logic [4:0] board_ry;
   logic       board_rdata;
   logic       board_we;
   logic [3:0] board_wx;
   logic [4:0] board_wy;
   logic       board_wdata;
   logic [2:0] dbg_state;

   // Handshake: start is a one-cycle request honoured only when busy=0; busy stays
   // high until the cycle after the single-cycle done pulse, and while busy=1 this
   // block alone owns the board ports (rdata answers the address of the previous cycle).
   modport master (
      input  start, board_rdata,
      output busy, done, lines_cleared, board_rx, board_ry,
             board_we, board_wx, board_wy, board_wdata, dbg_state
   );

   modport slave (
      output start, board_rdata,
      input  busy, done, lines_cleared, board_rx, board_ry,
             board_we, board_wx, board_wy, board_wdata, dbg_state
   );
endinterface

// File: rtl/line_clear_ctrl.sv
// Resolves a locked piece: scans the board bottom-up for full rows, compacts the
// surviving rows downward, zero-fills the vacated top rows and reports the count.
module line_clear_ctrl #(
   parameter int W = 10,
   parameter int H = 20
) (
   input logic               CLOCK_50,
   input logic               resetn,
   line_clear_ctrl_if.master bus
);
   localparam logic [3:0] COL_END  = 4'(W);
   localparam logic [3:0] COL_LAST = 4'(W - 1);
   localparam logic [4:0] ROW_LAST = 5'(H - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_DECIDE = 3'd2,
      S_COPY   = 3'd3,
      S_FILL   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] src_q, src_d;
   logic [4:0] dst_q, dst_d;
   logic [3:0] col_q, col_d;
   logic [4:0] cnt_q, cnt_d;
   logic       full_q, full_d;
   logic [4:0] lines_q, lines_d;

   logic [3:0] rx_c, wx_c;
   logic [4:0] ry_c, wy_c;
   logic       we_c, wdata_c, done_c;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         lines_q <= lines_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      lines_d = lines_q;
      rx_c    = '0;
      ry_c    = '0;
      we_c    = 1'b0;
      wx_c    = '0;
      wy_c    = '0;
      wdata_c = 1'b0;
      done_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CHECK;
               src_d   = ROW_LAST;
               dst_d   = ROW_LAST;
               col_d   = '0;
               cnt_d   = '0;
               full_d  = 1'b1;
            end
         end
         S_CHECK: begin
            if (col_q != COL_END) begin
               rx_c = col_q;
               ry_c = src_q;
            end
            // rdata lags the address by one cycle, so cycle 0 carries nothing yet
            if (col_q != 4'd0) full_d = full_q & bus.board_rdata;
            if (col_q == COL_END) begin
               state_d = S_DECIDE;
               col_d   = '0;
            end else begin
               col_d = col_q + 4'd1;
            end
         end
         S_DECIDE: begin
            col_d = '0;
            if (full_q || (src_q == dst_q)) begin
               if (full_q) cnt_d = cnt_q + 5'd1;
               else        dst_d = dst_q - 5'd1;
               src_d = src_q - 5'd1;
               // src==0 here means the decrement just walked past the top row
               if (src_q == 5'd0) begin
                  state_d = (full_q || (cnt_q != 5'd0)) ? S_FILL : S_DONE;
               end else begin
                  state_d = S_CHECK;
                  full_d  = 1'b1;
               end
            end else begin
               state_d = S_COPY;
            end
         end
         S_COPY: begin
            if (col_q != COL_END) begin
               rx_c = col_q;
               ry_c = src_q;
            end
            if (col_q != 4'd0) begin
               we_c    = 1'b1;
               wx_c    = col_q - 4'd1;
               wy_c    = dst_q;
               wdata_c = bus.board_rdata;
            end
            if (col_q == COL_END) begin
               src_d   = src_q - 5'd1;
               dst_d   = dst_q - 5'd1;
               col_d   = '0;
               full_d  = 1'b1;
               state_d = (src_q == 5'd0) ? S_FILL : S_CHECK;
            end else begin
               col_d = col_q + 4'd1;
            end
         end
         S_FILL: begin
            we_c    = 1'b1;
            wx_c    = col_q;
            wy_c    = dst_q;
            wdata_c = 1'b0;
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (dst_q == 5'd0) state_d = S_DONE;
               else               dst_d   = dst_q - 5'd1;
            end else begin
               col_d = col_q + 4'd1;
            end
         end
         S_DONE: begin
            done_c  = 1'b1;
            lines_d = cnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = done_c;
   assign bus.lines_cleared = lines_q;
   assign bus.board_rx      = rx_c;
   assign bus.board_ry      = ry_c;
   assign bus.board_we      = we_c;
   assign bus.board_wx      = wx_c;
   assign bus.board_wy      = wy_c;
   assign bus.board_wdata   = wdata_c;
   assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: behavioural board RAM with one-cycle read latency,
// row-compaction reference model, directed and randomized boards.
module tb_line_clear_ctrl;
   localparam int W      = 10;
   localparam int H      = 20;
   localparam int BUDGET = 3000;
   localparam logic [W-1:0] FULL_ROW = '1;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   line_clear_ctrl_if bus();

   line_clear_ctrl #(.W(W), .H(H)) dut (
      .CLOCK_50(clk),
      .resetn  (resetn),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] board_mem [H];
   logic [W-1:0] load_rows [H];
   logic         load_en = 1'b0;

   // Board RAM model: synchronous write, registered read
   always @(posedge clk) begin
      if (load_en) begin
         for (int y = 0; y < H; y++) board_mem[y] <= load_rows[y];
      end else if (bus.board_we === 1'b1) begin
         board_mem[bus.board_wy][bus.board_wx] <= bus.board_wdata;
      end
      bus.board_rdata <= board_mem[bus.board_ry][bus.board_rx];
   end

   logic [W-1:0] cur_rows [H];
   logic [W-1:0] exp_rows [H];
   int           exp_cnt;
   int           exp_copies;

   // Reference: full rows vanish, surviving rows keep their order and sink to the bottom.
   function automatic void build_expected();
      logic [W-1:0] exp_q[$];
      exp_cnt    = 0;
      exp_copies = 0;
      for (int y = H - 1; y >= 0; y--) begin
         if (cur_rows[y] == FULL_ROW) begin
            exp_cnt++;
         end else begin
            exp_q.push_back(cur_rows[y]);
            if (exp_cnt > 0) exp_copies++;
         end
      end
      for (int y = 0; y < H; y++) exp_rows[y] = '0;
      for (int i = 0; i < exp_q.size(); i++) exp_rows[H - 1 - i] = exp_q[i];
   endfunction

   task automatic load_board();
      for (int y = 0; y < H; y++) load_rows[y] = cur_rows[y];
      load_en = 1'b1;
      @(posedge clk);
      #1;
      load_en = 1'b0;
   endtask

   task automatic clear_cur();
      for (int y = 0; y < H; y++) cur_rows[y] = '0;
   endtask

   function automatic logic [W-1:0] rand_partial_row();
      logic [W-1:0] v;
      v = W'($urandom_range(0, (1 << W) - 1));
      if (v == FULL_ROW) v[$urandom_range(0, W - 1)] = 1'b0;
      return v;
   endfunction

   task automatic run_job(input string name, input bit poke_start);
      int cyc, done_cyc, we_cnt, busy_bad, extra;
      int exp_done_cyc, exp_we;
      bit poked, finished;
      build_expected();
      exp_done_cyc = 12 * H + (W + 1) * exp_copies + W * exp_cnt + 1;
      exp_we       = W * (exp_copies + exp_cnt);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 1; done_cyc = 0; we_cnt = 0; busy_bad = 0;
      poked = 1'b0; finished = 1'b0;
      while (!finished && cyc < BUDGET) begin
         if (bus.start) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            done_cyc = cyc;
            finished = 1'b1;
         end else begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.board_we === 1'b1) begin
               we_cnt++;
               if (poke_start && !poked) begin
                  bus.start = 1'b1;
                  poked = 1'b1;
               end
            end
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL %s/timeout: no done within %0d cycles", name, BUDGET);
         return;
      end
      checks++;
      if (done_cyc != exp_done_cyc) begin
         errors++;
         $display("FAIL %s/done_cycle: got %0d expected %0d", name, done_cyc, exp_done_cyc);
      end
      checks++;
      if (we_cnt != exp_we) begin
         errors++;
         $display("FAIL %s/we_cycles: got %0d expected %0d", name, we_cnt, exp_we);
      end
      checks++;
      if (busy_bad != 0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL %s/busy_during_run: low in %0d cycles, busy at done %b expected 1",
                  name, busy_bad, bus.busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL %s/after_done: busy %b done %b expected 0 0", name, bus.busy, bus.done);
      end
      checks++;
      if (bus.lines_cleared !== 5'(exp_cnt)) begin
         errors++;
         $display("FAIL %s/lines_cleared: got %0d expected %0d", name, bus.lines_cleared, exp_cnt);
      end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.board_we !== 1'b0) extra++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL %s/idle_after: activity in %0d idle cycles expected 0", name, extra);
      end
      for (int y = 0; y < H; y++) begin
         checks++;
         if (board_mem[y] !== exp_rows[y]) begin
            errors++;
            $display("FAIL %s/row%0d: got %b expected %b", name, y, board_mem[y], exp_rows[y]);
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      clear_cur();
      resetn = 1'b0;
      load_board();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lines_cleared !== 5'd0) begin
         errors++;
         $display("FAIL reset/status: busy %b done %b lines %0d expected 0 0 0",
                  bus.busy, bus.done, bus.lines_cleared);
      end
      checks++;
      if (bus.board_we !== 1'b0 || bus.board_wdata !== 1'b0) begin
         errors++;
         $display("FAIL reset/write: we %b wdata %b expected 0 0", bus.board_we, bus.board_wdata);
      end
      checks++;
      if (bus.board_rx !== 4'd0 || bus.board_ry !== 5'd0 ||
          bus.board_wx !== 4'd0 || bus.board_wy !== 5'd0) begin
         errors++;
         $display("FAIL reset/addr: rx %0d ry %0d wx %0d wy %0d expected all 0",
                  bus.board_rx, bus.board_ry, bus.board_wx, bus.board_wy);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_empty();
      clear_cur();
      load_board();
      run_job("empty", 1'b0);
   endtask

   task automatic test_single_row();
      clear_cur();
      cur_rows[19] = FULL_ROW;
      cur_rows[18] = W'(1 << 3);
      load_board();
      run_job("single_row", 1'b0);
   endtask

   task automatic test_two_rows();
      clear_cur();
      cur_rows[19] = FULL_ROW;
      cur_rows[18] = W'(1 << 0);
      cur_rows[17] = FULL_ROW;
      cur_rows[16] = W'(1 << 9);
      load_board();
      run_job("two_rows", 1'b0);
   endtask

   task automatic test_all_full();
      for (int y = 0; y < H; y++) cur_rows[y] = FULL_ROW;
      load_board();
      run_job("all_full", 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         for (int y = 0; y < H; y++) begin
            case ($urandom_range(0, 2))
               0:       cur_rows[y] = FULL_ROW;
               1:       cur_rows[y] = rand_partial_row();
               default: cur_rows[y] = '0;
            endcase
         end
         load_board();
         run_job($sformatf("random%0d", n), 1'b0);
      end
   endtask

   task automatic test_start_during_copy();
      clear_cur();
      cur_rows[19] = FULL_ROW;
      for (int y = 10; y < 19; y++) cur_rows[y] = rand_partial_row();
      cur_rows[12] = FULL_ROW;
      load_board();
      run_job("start_in_copy", 1'b1);
   endtask

   task automatic test_reset_during_copy();
      int cyc;
      clear_cur();
      cur_rows[19] = FULL_ROW;
      cur_rows[18] = 10'h155;
      cur_rows[17] = 10'h2AA;
      load_board();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 0;
      while (bus.board_we !== 1'b1 && cyc < BUDGET) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc >= BUDGET) begin
         errors++;
         $display("FAIL reset_in_copy/reach_copy: no write within %0d cycles", BUDGET);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.board_we !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_copy/async: busy %b we %b done %b expected 0 0 0",
                  bus.busy, bus.board_we, bus.done);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      for (int y = 0; y < H; y++) cur_rows[y] = (y % 3 == 0) ? FULL_ROW : rand_partial_row();
      load_board();
      run_job("after_reset", 1'b0);
   endtask

   initial begin
      bus.start = 1'b0;
      test_reset();
      test_empty();
      test_single_row();
      test_two_rows();
      test_all_full();
      test_random();
      test_start_during_copy();
      test_reset_during_copy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
